// File: rtl/cache_refill_ctrl_pkg.sv
// cache_refill_ctrl_pkg: shared widths, FSM states and address-field helpers for the refill controller.
package cache_refill_ctrl_pkg;
    localparam int ADDR_W  = 32;
    localparam int INDEX_W = 8;
    localparam int LINE_W  = 128;
    localparam int WORD_W  = 32;
    localparam int BEATS   = LINE_W / WORD_W;
    localparam int TAG_W   = ADDR_W - 12;

    typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_DATA, INSTALL, ACK} state_t;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:12];
    endfunction

    function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] a);
        return a[11:4];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:4], 4'h0};
    endfunction
endpackage

// File: rtl/cache_refill_ctrl_lru.sv
// lru_table: 1-bit LRU per set, async reset, async read; a fill write overrides a hit write to the same set.
module lru_table
    import cache_refill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               hit_we_i,
    input  logic [INDEX_W-1:0] hit_idx_i,
    input  logic               hit_val_i,
    input  logic               fill_we_i,
    input  logic [INDEX_W-1:0] fill_idx_i,
    input  logic               fill_val_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_o
);
    logic [2**INDEX_W-1:0] lru_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_q <= '0;
        end else begin
            if (hit_we_i) lru_q[hit_idx_i] <= hit_val_i;
            if (fill_we_i) lru_q[fill_idx_i] <= fill_val_i;
        end
    end

    assign rd_o = lru_q[rd_idx_i];
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: 2-way cache miss sequencer (victim pick, optional write-back, 4-beat refill, install).
// Define CACHE_WB_EN for a write-back cache; otherwise write-through and the WB state is unreachable.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_req,
    input  logic [ADDR_W-1:0]  miss_addr,
    output logic               miss_ack,
    output logic               busy,
    input  logic               hit_valid,
    input  logic [INDEX_W-1:0] hit_index,
    input  logic               hit_way,
    input  logic               victim_dirty,
    input  logic [TAG_W-1:0]   victim_tag,
    input  logic [LINE_W-1:0]  victim_data,
    output logic [INDEX_W-1:0] rd_index,
    output logic               refill_way,
    output logic [1:0]         way_we,
    output logic [INDEX_W-1:0] way_windex,
    output logic [LINE_W-1:0]  way_wdata,
    output logic               mem_rd_valid,
    input  logic               mem_rd_ready,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic               mem_rdata_valid,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic               mem_wr_valid,
    input  logic               mem_wr_ready,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [WORD_W-1:0]  mem_wr_data,
    output logic               mem_wr_last
);
    localparam logic [1:0] LAST = 2'(BEATS - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   wa_q;
    logic                way_q;
    logic [1:0]          cnt_q;
    logic [LINE_W-1:0]   buf_q;
    logic [LINE_W-1:0]   wb_q;
    logic                lru_rd;
    logic                to_wb;

`ifdef CACHE_WB_EN
    assign to_wb        = victim_dirty;
    assign mem_wr_valid = state_q == WB;
`else
    logic unused_dirty;
    assign unused_dirty = victim_dirty;
    assign to_wb        = 1'b0;
    assign mem_wr_valid = 1'b0;
`endif

    lru_table u_lru (
        .clk       (clk),
        .rst       (rst),
        .hit_we_i  (hit_valid),
        .hit_idx_i (hit_index),
        .hit_val_i (~hit_way),
        .fill_we_i (state_q == INSTALL),
        .fill_idx_i(index_of(addr_q)),
        .fill_val_i(~way_q),
        .rd_idx_i  (index_of(miss_addr)),
        .rd_o      (lru_rd)
    );

    // Victim data and address are snapshotted at accept so the write-back is immune to array changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wa_q    <= '0;
            way_q   <= 1'b0;
            cnt_q   <= '0;
            buf_q   <= '0;
            wb_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (miss_req) begin
                    addr_q  <= line_addr(miss_addr);
                    way_q   <= lru_rd;
                    wb_q    <= victim_data;
                    wa_q    <= {victim_tag, index_of(miss_addr), 4'h0};
                    cnt_q   <= '0;
                    state_q <= to_wb ? WB : RD_REQ;
                end
                WB: if (mem_wr_ready) begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAST) state_q <= RD_REQ;
                end
                RD_REQ: if (mem_rd_ready) state_q <= RD_DATA;
                RD_DATA: if (mem_rdata_valid) begin
                    buf_q[cnt_q*WORD_W +: WORD_W] <= mem_rdata;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAST) state_q <= INSTALL;
                end
                INSTALL: state_q <= ACK;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = state_q != IDLE;
    assign miss_ack     = state_q == ACK;
    assign rd_index     = busy ? index_of(addr_q) : index_of(miss_addr);
    assign refill_way   = busy ? way_q : lru_rd;
    assign way_we       = state_q == INSTALL ? (way_q ? 2'b10 : 2'b01) : 2'b00;
    assign way_windex   = index_of(addr_q);
    assign way_wdata    = buf_q;
    assign mem_rd_valid = state_q == RD_REQ;
    assign mem_rd_addr  = addr_q;
    assign mem_wr_addr  = wa_q;
    assign mem_wr_data  = wb_q[cnt_q*WORD_W +: WORD_W];
    assign mem_wr_last  = mem_wr_valid && cnt_q == LAST;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: table-driven refill sequences plus reset, hit and write-back corner cases.
module tb_cache_refill_ctrl;
    import cache_refill_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               miss_req, miss_ack, busy;
    logic [ADDR_W-1:0]  miss_addr;
    logic               hit_valid, hit_way;
    logic [INDEX_W-1:0] hit_index;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic [LINE_W-1:0]  victim_data;
    logic [INDEX_W-1:0] rd_index;
    logic               refill_way;
    logic [1:0]         way_we;
    logic [INDEX_W-1:0] way_windex;
    logic [LINE_W-1:0]  way_wdata;
    logic               mem_rd_valid, mem_rd_ready;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic               mem_rdata_valid;
    logic [WORD_W-1:0]  mem_rdata;
    logic               mem_wr_valid, mem_wr_ready, mem_wr_last;
    logic [ADDR_W-1:0]  mem_wr_addr;
    logic [WORD_W-1:0]  mem_wr_data;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
        .busy(busy), .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
        .rd_index(rd_index), .refill_way(refill_way), .way_we(way_we), .way_windex(way_windex),
        .way_wdata(way_wdata), .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rd_addr(mem_rd_addr), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] line;
        int           stall;
        bit           gap;
        bit           hit_en;
        logic [7:0]   hit_idx;
        bit           hit_way;
        bit           dirty;
        logic         exp_way;
        logic [31:0]  exp_rd;
        logic         exp_lru;
    } vec_t;

    vec_t v[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_miss(input vec_t t);
        int  n;
        bit  wr_seen;
        bit  held;
        n = 0;
        wr_seen = 0;
        held = 1;
        miss_addr = t.addr;
        miss_req = 1'b1;
        victim_dirty = t.dirty;
        do begin
            @(negedge clk);
            n++;
            if (mem_wr_valid) wr_seen = 1;
        end while (!mem_rd_valid && n < 40);
        chk("rd_valid_seen", mem_rd_valid, 1'b1);
        chk("refill_way", refill_way, t.exp_way);
        chk("rd_addr", mem_rd_addr, t.exp_rd);
        chk("rd_index", rd_index, t.addr[11:4]);
`ifndef CACHE_WB_EN
        chk("wr_valid_tied0", wr_seen, 1'b0);
`endif
        victim_dirty = 1'b0;
        repeat (t.stall) begin
            @(negedge clk);
            if (!mem_rd_valid || mem_rd_addr !== t.exp_rd) held = 0;
        end
        if (t.stall > 0) chk("rd_hold", held, 1'b1);
        mem_rd_ready = 1'b1;
        @(negedge clk);
        mem_rd_ready = 1'b0;
        chk("rd_valid_drop", mem_rd_valid, 1'b0);
        for (int b = 0; b < 4; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = t.line[b*32 +: 32];
            @(negedge clk);
            mem_rdata_valid = 1'b0;
            if (t.gap && b < 3) begin
                mem_rdata = 32'hDEADBEEF;
                @(negedge clk);
            end
        end
        if (t.hit_en) begin
            hit_valid = 1'b1;
            hit_index = t.hit_idx;
            hit_way = t.hit_way;
        end
        chk("way_we", way_we, t.exp_way ? 2'b10 : 2'b01);
        chk("way_windex", way_windex, t.addr[11:4]);
        chk("way_wdata", way_wdata, t.line);
        chk("ack_early", miss_ack, 1'b0);
        @(negedge clk);
        hit_valid = 1'b0;
        chk("miss_ack", miss_ack, 1'b1);
        chk("we_one_cycle", way_we, 2'b00);
        miss_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", miss_ack, 1'b0);
        chk("idle", busy, 1'b0);
        miss_addr = t.addr;
        #1;
        chk("lru_after", refill_way, t.exp_lru);
    endtask

    task automatic lru_at(input string name, input logic [31:0] a, input logic exp);
        miss_addr = a;
        #1;
        chk(name, refill_way, exp);
    endtask

    initial begin
        int   n;
        bit   held;
        vec_t r;
        logic [127:0] wl;

        v[0] = '{32'h0000_1230, 128'h00000044_00000033_00000022_00000011, 0, 0, 1, 8'h23, 1, 0,
                 1'b0, 32'h0000_1230, 1'b1};
        v[1] = '{32'h0000_5238, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001, 5, 1, 0, 8'h00, 0, 0,
                 1'b1, 32'h0000_5230, 1'b0};
        v[2] = '{32'h0000_045C, 128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001, 0, 0, 1, 8'h77, 0, 0,
                 1'b0, 32'h0000_0450, 1'b1};
`ifdef CACHE_WB_EN
        v[3] = '{32'hFFFF_FFFC, 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, 1, 1, 0, 8'h00, 0, 0,
                 1'b0, 32'hFFFF_FFF0, 1'b1};
`else
        v[3] = '{32'hFFFF_FFFC, 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0, 1, 1, 0, 8'h00, 0, 1,
                 1'b0, 32'hFFFF_FFF0, 1'b1};
`endif

        rst = 1'b1;
        miss_req = 0; miss_addr = 32'h0000_1230;
        hit_valid = 0; hit_index = '0; hit_way = 0;
        victim_dirty = 0; victim_tag = '0; victim_data = '0;
        mem_rd_ready = 0; mem_rdata_valid = 0; mem_rdata = '0; mem_wr_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", miss_ack, 1'b0);
        chk("rst_we", way_we, 2'b00);
        chk("rst_rd_valid", mem_rd_valid, 1'b0);
        chk("rst_wr_valid", mem_wr_valid, 1'b0);
        chk("rst_lru", refill_way, 1'b0);
        chk("rst_wdata", way_wdata, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_miss(v[i]);
        lru_at("lru_other_set_hit", 32'h0000_0770, 1'b1);

        // Hits while idle
        hit_valid = 1; hit_index = 8'h45; hit_way = 1;
        @(negedge clk);
        hit_valid = 0;
        lru_at("hit_way1", 32'h0000_0450, 1'b0);
        hit_valid = 1; hit_way = 0;
        @(negedge clk);
        hit_valid = 0;
        lru_at("hit_way0", 32'h0000_0450, 1'b1);

        // Async reset in RD_DATA after two beats
        miss_addr = 32'h0000_2340;
        miss_req = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_rd_valid && n < 40);
        chk("rst_seq_rd_valid", mem_rd_valid, 1'b1);
        mem_rd_ready = 1;
        @(negedge clk);
        mem_rd_ready = 0;
        for (int b = 0; b < 2; b++) begin
            mem_rdata_valid = 1; mem_rdata = 32'hEE00_0000 + b;
            @(negedge clk);
        end
        mem_rdata_valid = 0;
        #2 rst = 1;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_we", way_we, 2'b00);
        chk("async_rd_valid", mem_rd_valid, 1'b0);
        lru_at("async_lru_clear", 32'hFFFF_FFF0, 1'b0);
        miss_addr = 32'h0000_2340;
        @(negedge clk);
        rst = 0;
        r = '{32'h0000_2340, 128'h44440004_44440003_44440002_44440001, 0, 0, 0, 8'h00, 0, 0,
              1'b0, 32'h0000_2340, 1'b1};
        run_miss(r);

`ifdef CACHE_WB_EN
        // Dirty victim write-back with a 5-cycle ready stall on beat 1
        wl = 128'hD0000003_D0000002_D0000001_D0000000;
        miss_addr = 32'h0000_1230; victim_dirty = 1; victim_tag = 20'hABCDE; victim_data = wl;
        miss_req = 1;
        @(negedge clk);
        victim_dirty = 0; victim_data = '0;
        chk("wb_addr", mem_wr_addr, 32'hABCD_E230);
        for (int b = 0; b < 4; b++) begin
            n = 0;
            while (!mem_wr_valid && n < 20) begin @(negedge clk); n++; end
            chk("wb_valid", mem_wr_valid, 1'b1);
            chk("wb_data", mem_wr_data, wl[b*32 +: 32]);
            chk("wb_last", mem_wr_last, b == 3);
            chk("wb_no_rd", mem_rd_valid, 1'b0);
            if (b == 1) begin
                held = 1;
                repeat (5) begin
                    @(negedge clk);
                    if (!mem_wr_valid || mem_wr_data !== wl[63:32]) held = 0;
                end
                chk("wb_hold", held, 1'b1);
            end
            mem_wr_ready = 1;
            @(negedge clk);
            mem_wr_ready = 0;
        end
        r = '{32'h0000_1230, 128'h00000044_00000033_00000022_00000011, 0, 0, 0, 8'h00, 0, 0,
              1'b0, 32'h0000_1230, 1'b1};
        run_miss(r);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
